// File: rtl/soft_ramp_ctrl_if.sv
// Soft-ramp controller bus: supervisor-side requests and PWM-side duty/status.
// Latency: none, this is wires only.
// Backpressure: none. The request signals are levels that are sampled every cycle.
//
// Signals
//   i_enable   run request (level)
//   i_stop     soft-stop request (level)
//   i_fault    hard fault (level, highest priority)
//   i_target   requested steady-state duty
//   o_duty_sel registered duty selection
//   o_enable   PWM enable
//   o_done     steady state reached (RUN)
//   o_state    controller state: 0 IDLE, 1 UP, 2 RUN, 3 DOWN
//   o_fault    latched fault flag
interface soft_ramp_ctrl_if #(
    parameter int DUTY_W = 8
);
    logic              i_enable;
    logic              i_stop;
    logic              i_fault;
    logic [DUTY_W-1:0] i_target;
    logic [DUTY_W-1:0] o_duty_sel;
    logic              o_enable;
    logic              o_done;
    logic [1:0]        o_state;
    logic              o_fault;

    // Supervisor side: drives the requests and observes the duty and status.
    modport master (
        output i_enable, i_stop, i_fault, i_target,
        input  o_duty_sel, o_enable, o_done, o_state, o_fault
    );

    // Controller side.
    modport slave (
        input  i_enable, i_stop, i_fault, i_target,
        output o_duty_sel, o_enable, o_done, o_state, o_fault
    );
endinterface

// File: rtl/soft_ramp_ctrl.sv
// Soft-start/soft-stop duty ramp controller for the SMPS PWM path.
// Latency: one step every TS_DIV*STEP_DIV clocks while ramping. A fault zeroes the duty on the next edge.
// Backpressure: none. Requests are levels sampled every cycle, and the duty output is always valid.
//
// Ports
//   i_clk  system clock
//   reset  synchronous active-low reset
//   bus    soft_ramp_ctrl_if.slave (enable/stop/fault/target in; duty/enable/done/state/fault out)
module soft_ramp_ctrl #(
    parameter int DUTY_W    = 8,
    parameter int TS_DIV    = 1000,
    parameter int STEP_DIV  = 15000,
    parameter int TS_W      = 10,
    parameter int STEP_W    = 21,
    parameter int STEP_SIZE = 1
) (
    input  logic            i_clk,
    input  logic            reset,
    soft_ramp_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_RUN  = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    localparam logic [TS_W-1:0]   TS_LAST   = TS_W'(TS_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    // The step is held one bit wider so that sums against duty/floor cannot wrap.
    localparam logic [DUTY_W:0]   STEP_EXT  = (DUTY_W + 1)'(STEP_SIZE);

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q,  duty_d;
    logic [TS_W-1:0]   ts_q,    ts_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic              fault_q, fault_d;

    logic              go;
    logic              ramping;
    logic              ts_tick;
    logic              step_pulse;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] floor_val;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] up_val;
    logic [DUTY_W:0]   floor_plus;
    logic [DUTY_W-1:0] down_val;

    // ------------------------------------------------------------------
    // Run qualification and prescaler decode
    // ------------------------------------------------------------------
    // A latched fault blocks any restart until the supervisor drops i_enable.
    assign go         = bus.i_enable & ~bus.i_stop & ~fault_q;
    assign ramping    = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign ts_tick    = ramping && (ts_q == TS_LAST);
    assign step_pulse = ts_tick && (step_q == STEP_LAST);

    assign target     = bus.i_target;
    // When stopping, the ramp goes all the way to zero. Otherwise it settles at the new lower target.
    assign floor_val  = go ? target : '0;

    // Ramp-up is saturated at the target. The sum carries one extra bit so it cannot wrap.
    assign up_sum     = {1'b0, duty_q} + STEP_EXT;
    assign up_val     = (up_sum >= {1'b0, target}) ? target : up_sum[DUTY_W-1:0];

    // Ramp-down is clamped at the floor. The subtraction happens only when it cannot pass the floor.
    assign floor_plus = {1'b0, floor_val} + STEP_EXT;
    assign down_val   = ({1'b0, duty_q} >= floor_plus) ? (duty_q - STEP_EXT[DUTY_W-1:0])
                                                       : floor_val;

    // ------------------------------------------------------------------
    // Next-state / next-duty
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        fault_d = fault_q;

        if (bus.i_fault) begin
            state_d = ST_IDLE;
            duty_d  = '0;
            fault_d = 1'b1;
        end else begin
            if (fault_q && !bus.i_enable) begin
                fault_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    if (go && (target != '0)) begin
                        state_d = ST_UP;
                    end
                end

                ST_UP: begin
                    if (!go || (target < duty_q)) begin
                        state_d = ST_DOWN;
                    end else if (duty_q == target) begin
                        state_d = ST_RUN;
                    end else if (step_pulse) begin
                        duty_d = up_val;
                    end
                end

                ST_RUN: begin
                    if (!go || (target < duty_q)) begin
                        state_d = ST_DOWN;
                    end else if (target > duty_q) begin
                        state_d = ST_UP;
                    end
                end

                ST_DOWN: begin
                    if (go && (target > duty_q)) begin
                        state_d = ST_UP;
                    end else if (duty_q == floor_val) begin
                        state_d = (floor_val == '0) ? ST_IDLE : ST_RUN;
                    end else if (step_pulse) begin
                        duty_d = down_val;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: free-runs only while the FSM stays in UP or DOWN. It returns to zero
    // on any state change, so every new ramp waits one full step period.
    // ------------------------------------------------------------------
    always_comb begin
        ts_d   = '0;
        step_d = '0;
        if (ramping && (state_d == state_q)) begin
            if (ts_tick) begin
                ts_d   = '0;
                step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
            end else begin
                ts_d   = ts_q + 1'b1;
                step_d = step_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            ts_q    <= '0;
            step_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            ts_q    <= ts_d;
            step_q  <= step_d;
            fault_q <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded directly from registers
    // ------------------------------------------------------------------
    assign bus.o_duty_sel = duty_q;
    assign bus.o_state    = state_q;
    assign bus.o_done     = (state_q == ST_RUN);
    assign bus.o_enable   = (state_q != ST_IDLE) && (duty_q != '0);
    assign bus.o_fault    = fault_q;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_idle_zero : assert property (@(posedge i_clk) disable iff (!reset)
        (state_q == ST_IDLE) |-> (duty_q == '0));
    a_fault_idle : assert property (@(posedge i_clk) disable iff (!reset)
        fault_q |-> (state_q == ST_IDLE));
    a_presc_hold : assert property (@(posedge i_clk) disable iff (!reset)
        !ramping |-> ((ts_q == '0) && (step_q == '0)));

endmodule

// File: tb/tb_soft_ramp_ctrl.sv
// Bench for soft_ramp_ctrl: directed ramp scenarios plus randomized traffic against a reference model.
// Latency: the model advances once per clock edge, and outputs are compared 1 time unit after the edge.
// Backpressure: not applicable. Two DUTs share the same stimulus (STEP_SIZE 3 and 100).
module tb_soft_ramp_ctrl;

    localparam int PERIOD = 8;      // TS_DIV * STEP_DIV

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, stop, flt;
    logic [7:0] tgt;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    soft_ramp_ctrl_if #(.DUTY_W(8)) ifa ();
    soft_ramp_ctrl_if #(.DUTY_W(8)) ifb ();

    assign ifa.i_enable = en;
    assign ifa.i_stop   = stop;
    assign ifa.i_fault  = flt;
    assign ifa.i_target = tgt;
    assign ifb.i_enable = en;
    assign ifb.i_stop   = stop;
    assign ifb.i_fault  = flt;
    assign ifb.i_target = tgt;

    soft_ramp_ctrl #(.DUTY_W(8), .TS_DIV(4), .STEP_DIV(2), .TS_W(2), .STEP_W(1), .STEP_SIZE(3))
        dut_a (.i_clk(clk), .reset(rst_n), .bus(ifa.slave));
    soft_ramp_ctrl #(.DUTY_W(8), .TS_DIV(4), .STEP_DIV(2), .TS_W(2), .STEP_W(1), .STEP_SIZE(100))
        dut_b (.i_clk(clk), .reset(rst_n), .bus(ifb.slave));

    // Reference model. st: 0 IDLE, 1 UP, 2 RUN, 3 DOWN. cnt counts the clocks spent in the current ramp state.
    typedef struct {
        int st;
        int duty;
        bit flt;
        int cnt;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t model_next(input mdl_t m, input bit rn, input bit e, input bit s,
                                        input bit f, input int t, input int stp);
        mdl_t n;
        bit   go;
        int   fl;
        bit   due;
        n = '{default: 0};
        if (!rn) return n;
        if (f) begin
            n.flt = 1'b1;
            return n;
        end
        n = m;
        if (!e) n.flt = 1'b0;
        go  = e && !s && !m.flt;
        fl  = go ? t : 0;
        due = ((m.cnt + 1) % PERIOD) == 0;
        case (m.st)
            0: if (go && t != 0) n.st = 1;
            1: begin
                if (!go || t < m.duty)  n.st = 3;
                else if (m.duty == t)   n.st = 2;
                else if (due)           n.duty = (m.duty + stp > t) ? t : m.duty + stp;
            end
            2: begin
                if (!go || t < m.duty)  n.st = 3;
                else if (t > m.duty)    n.st = 1;
            end
            3: begin
                if (go && t > m.duty)   n.st = 1;
                else if (m.duty == fl)  n.st = (fl == 0) ? 0 : 2;
                else if (due)           n.duty = (m.duty - stp < fl) ? fl : m.duty - stp;
            end
            default: n.st = 0;
        endcase
        n.cnt = (n.st != m.st || n.st == 0 || n.st == 2) ? 0 : m.cnt + 1;
        return n;
    endfunction

    // Packs the model's expected outputs as {duty, state, done, enable, fault}.
    function automatic logic [12:0] pack_m(input mdl_t m);
        return {8'(m.duty), 2'(m.st), 1'(m.st == 2), 1'(m.st != 0 && m.duty != 0), m.flt};
    endfunction

    task automatic tick();
        @(posedge clk);
        ma = model_next(ma, rst_n, en, stop, flt, int'(tgt), 3);
        mb = model_next(mb, rst_n, en, stop, flt, int'(tgt), 100);
        #1;
    endtask

    task automatic wait_run(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ifa.o_state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; tgt = 8'd50;
        repeat (3) tick();
        total++; if (ifa.o_duty_sel !== 8'd0) begin bad++; $display("FAIL reset_duty got=%0d want=0", ifa.o_duty_sel); end
        total++; if (ifa.o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", ifa.o_state); end
        total++; if (ifa.o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", ifa.o_done); end
        total++; if (ifa.o_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", ifa.o_fault); end
        total++; if (ifa.o_enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%0b want=0", ifa.o_enable); end
    endtask

    task automatic test_ramp_up();
        int ed;
        rst_n = 1'b1; en = 1'b1; tgt = 8'd10;
        tick();
        total++; if (ifa.o_state !== 2'd1) begin bad++; $display("FAIL up_entry state got=%0d want=1", ifa.o_state); end
        for (int k = 1; k <= 33; k++) begin
            tick();
            ed = (k < 8) ? 0 : (k < 16) ? 3 : (k < 24) ? 6 : (k < 32) ? 9 : 10;
            total++; if (ifa.o_duty_sel !== 8'(ed)) begin bad++; $display("FAIL up_duty k=%0d got=%0d want=%0d", k, ifa.o_duty_sel, ed); end
            total++; if (ifa.o_enable !== (ed != 0)) begin bad++; $display("FAIL up_enable k=%0d got=%0b want=%0b", k, ifa.o_enable, ed != 0); end
            if (k == 32) begin
                total++; if (ifa.o_state !== 2'd1) begin bad++; $display("FAIL up_sat_state got=%0d want=1", ifa.o_state); end
            end
        end
        total++; if (ifa.o_state !== 2'd2) begin bad++; $display("FAIL up_run_state got=%0d want=2", ifa.o_state); end
        total++; if (ifa.o_done !== 1'b1) begin bad++; $display("FAIL up_done got=%0b want=1", ifa.o_done); end
    endtask

    task automatic test_stop();
        int ed;
        stop = 1'b1;
        tick();
        total++; if (ifa.o_state !== 2'd3 || ifa.o_done !== 1'b0) begin bad++; $display("FAIL stop_entry state=%0d done=%0b want 3/0", ifa.o_state, ifa.o_done); end
        for (int k = 1; k <= 33; k++) begin
            tick();
            ed = (k < 8) ? 10 : (k < 16) ? 7 : (k < 24) ? 4 : (k < 32) ? 1 : 0;
            total++; if (ifa.o_duty_sel !== 8'(ed)) begin bad++; $display("FAIL stop_duty k=%0d got=%0d want=%0d", k, ifa.o_duty_sel, ed); end
            total++; if (ifa.o_enable !== (ed != 0)) begin bad++; $display("FAIL stop_enable k=%0d got=%0b want=%0b", k, ifa.o_enable, ed != 0); end
        end
        total++; if (ifa.o_state !== 2'd0) begin bad++; $display("FAIL stop_idle state got=%0d want=0", ifa.o_state); end
    endtask

    task automatic test_retarget();
        bit ok;
        int ed;
        stop = 1'b0; tgt = 8'd10;
        wait_run(100, ok);
        total++; if (!ok || ifa.o_duty_sel !== 8'd10) begin bad++; $display("FAIL rt_prep ok=%0b duty=%0d want RUN at 10", ok, ifa.o_duty_sel); end
        tgt = 8'd4;
        tick();
        total++; if (ifa.o_state !== 2'd3) begin bad++; $display("FAIL rt_down_entry got=%0d want=3", ifa.o_state); end
        for (int k = 1; k <= 17; k++) begin
            tick();
            ed = (k < 8) ? 10 : (k < 16) ? 7 : 4;
            total++; if (ifa.o_duty_sel !== 8'(ed)) begin bad++; $display("FAIL rt_duty k=%0d got=%0d want=%0d", k, ifa.o_duty_sel, ed); end
        end
        total++; if (ifa.o_state !== 2'd2 || ifa.o_done !== 1'b1) begin bad++; $display("FAIL rt_run state=%0d done=%0b want 2/1", ifa.o_state, ifa.o_done); end
        tgt = 8'd200;
        tick();
        total++; if (ifa.o_state !== 2'd1) begin bad++; $display("FAIL rt_up_entry got=%0d want=1", ifa.o_state); end
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            total++; if ({ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault} !== pack_m(ma)) begin
                bad++; $display("FAIL rt_up_model k=%0d got=%h want=%h", k, {ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault}, pack_m(ma));
            end
            if (ifa.o_state == 2'd2) begin ok = 1'b1; break; end
        end
        total++; if (!ok || ifa.o_duty_sel !== 8'd200) begin bad++; $display("FAIL rt_reach200 ok=%0b duty=%0d want 200", ok, ifa.o_duty_sel); end
    endtask

    task automatic test_fault();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; en = 1'b1; stop = 1'b0; tgt = 8'd10;
        tick();
        repeat (16) tick();
        total++; if (ifa.o_duty_sel !== 8'd6) begin bad++; $display("FAIL flt_prep duty got=%0d want=6", ifa.o_duty_sel); end
        flt = 1'b1; tick(); flt = 1'b0;
        total++; if (ifa.o_duty_sel !== 8'd0 || ifa.o_state !== 2'd0) begin bad++; $display("FAIL flt_shutdown duty=%0d state=%0d want 0/0", ifa.o_duty_sel, ifa.o_state); end
        total++; if (ifa.o_fault !== 1'b1 || ifa.o_enable !== 1'b0) begin bad++; $display("FAIL flt_flag fault=%0b en=%0b want 1/0", ifa.o_fault, ifa.o_enable); end
        repeat (5) tick();
        total++; if (ifa.o_fault !== 1'b1 || ifa.o_state !== 2'd0) begin bad++; $display("FAIL flt_held fault=%0b state=%0d want 1/0", ifa.o_fault, ifa.o_state); end
        en = 1'b0; tick();
        total++; if (ifa.o_fault !== 1'b0) begin bad++; $display("FAIL flt_clear got=%0b want=0", ifa.o_fault); end
        en = 1'b1; tick();
        total++; if (ifa.o_state !== 2'd1) begin bad++; $display("FAIL flt_restart state got=%0d want=1", ifa.o_state); end
        repeat (7) tick();
        total++; if (ifa.o_duty_sel !== 8'd0) begin bad++; $display("FAIL flt_pre_step duty got=%0d want=0", ifa.o_duty_sel); end
        tick();
        total++; if (ifa.o_duty_sel !== 8'd3) begin bad++; $display("FAIL flt_first_step duty got=%0d want=3", ifa.o_duty_sel); end
    endtask

    task automatic test_reset_midramp();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; en = 1'b1; tgt = 8'd10;
        tick();
        repeat (24) tick();
        total++; if (ifa.o_duty_sel !== 8'd9) begin bad++; $display("FAIL rst_prep duty got=%0d want=9", ifa.o_duty_sel); end
        rst_n = 1'b0; tick();
        total++; if ({ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault} !== 13'd0) begin
            bad++; $display("FAIL rst_mid outputs got=%h want=0", {ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault});
        end
        rst_n = 1'b1; tick();
        total++; if (ifa.o_state !== 2'd1) begin bad++; $display("FAIL rst_up_entry got=%0d want=1", ifa.o_state); end
        repeat (7) tick();
        total++; if (ifa.o_duty_sel !== 8'd0) begin bad++; $display("FAIL rst_pre_step duty got=%0d want=0", ifa.o_duty_sel); end
        tick();
        total++; if (ifa.o_duty_sel !== 8'd3) begin bad++; $display("FAIL rst_first_step duty got=%0d want=3", ifa.o_duty_sel); end
    endtask

    task automatic test_saturation();
        int ed;
        rst_n = 1'b0; tick();
        rst_n = 1'b1; en = 1'b1; tgt = 8'd0;
        repeat (10) tick();
        total++; if (ifa.o_state !== 2'd0 || ifa.o_duty_sel !== 8'd0) begin bad++; $display("FAIL zero_tgt_a state=%0d duty=%0d want 0/0", ifa.o_state, ifa.o_duty_sel); end
        total++; if (ifb.o_state !== 2'd0 || ifb.o_duty_sel !== 8'd0) begin bad++; $display("FAIL zero_tgt_b state=%0d duty=%0d want 0/0", ifb.o_state, ifb.o_duty_sel); end
        tgt = 8'd255;
        tick();
        for (int k = 1; k <= 25; k++) begin
            tick();
            ed = (k < 8) ? 0 : (k < 16) ? 100 : (k < 24) ? 200 : 255;
            total++; if (ifb.o_duty_sel !== 8'(ed)) begin bad++; $display("FAIL sat_duty k=%0d got=%0d want=%0d", k, ifb.o_duty_sel, ed); end
            total++; if ({ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault} !== pack_m(ma)) begin
                bad++; $display("FAIL sat_a_model k=%0d got=%h want=%h", k, {ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault}, pack_m(ma));
            end
        end
        total++; if (ifb.o_state !== 2'd2 || ifb.o_done !== 1'b1) begin bad++; $display("FAIL sat_run state=%0d done=%0b want 2/1", ifb.o_state, ifb.o_done); end
    endtask

    task automatic test_random();
        rst_n = 1'b1; en = 1'b1; stop = 1'b0; flt = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 999) >= 3);
            flt   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 99) < 2) stop = ~stop;
            if ($urandom_range(0, 99) < 4)
                tgt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            tick();
            total++; if ({ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault} !== pack_m(ma)) begin
                bad++; $display("FAIL rand_a c=%0d got=%h want=%h", c, {ifa.o_duty_sel, ifa.o_state, ifa.o_done, ifa.o_enable, ifa.o_fault}, pack_m(ma));
            end
            total++; if ({ifb.o_duty_sel, ifb.o_state, ifb.o_done, ifb.o_enable, ifb.o_fault} !== pack_m(mb)) begin
                bad++; $display("FAIL rand_b c=%0d got=%h want=%h", c, {ifb.o_duty_sel, ifb.o_state, ifb.o_done, ifb.o_enable, ifb.o_fault}, pack_m(mb));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; stop = 1'b0; flt = 1'b0; tgt = 8'd0;
        ma = '{default: 0};
        mb = '{default: 0};
        test_reset();
        test_ramp_up();
        test_stop();
        test_retarget();
        test_fault();
        test_reset_midramp();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soft_ramp_ctrl.md
Name: soft_ramp_ctrl

Overview:
Parametrised soft-start/soft-stop duty ramp controller for the SMPS PWM path. It ramps o_duty_sel from 0 toward a runtime-programmable target in fixed-size steps at a prescaled rate. It tracks target changes with the same ramp, ramps down to 0 on disable or stop, and forces the duty to zero immediately on a fault. It sits between the supervisory logic and the PWM duty selector, and is the generalised successor to the fixed-limit soft-start.

Parameters:
DUTY_W, 8, width of duty selector and target
TS_DIV, 1000, clocks per time-slice tick (≥2)
STEP_DIV, 15000, time-slice ticks per duty step (≥1)
TS_W, 10, width of time-slice counter (holds TS_DIV-1)
STEP_W, 21, width of step counter (holds STEP_DIV-1)
STEP_SIZE, 1, duty increment/decrement per step (≥1, < 2^DUTY_W)

Ports:
i_clk  in  1  system clock
reset  in  1  synchronous, active-low reset
i_enable  in  1  run request; low forces soft ramp-down to 0
i_stop  in  1  soft-stop request; same effect as i_enable low while high
i_fault  in  1  hard fault; immediate shutdown
i_target  in  DUTY_W  requested steady-state duty, sampled every cycle
o_duty_sel  out  DUTY_W  current duty selection (registered)
o_enable  out  1  PWM enable
o_done  out  1  high in RUN (duty == target)
o_state  out  2  FSM state: 0 IDLE, 1 UP, 2 RUN, 3 DOWN
o_fault  out  1  latched fault flag

Behaviour:
- One clock domain; all state updates on posedge i_clk. reset is sampled only on the clock edge, active-low.
- Reset (reset==0): o_duty_sel=0, state IDLE, o_done=0, o_fault=0, both prescaler counters 0. Reset mid-ramp aborts immediately to these values.
- o_enable = (state != IDLE) && (o_duty_sel != 0). It is combinational from registers.
- "go" = i_enable && !i_stop && !o_fault.
- Prescaler: the ts counter counts 0..TS_DIV-1 and emits a tick at TS_DIV-1. The step counter advances on each tick and emits a step pulse on a tick when it equals STEP_DIV-1. Both wrap to 0.
- The prescaler runs only in UP and DOWN. It is held at 0 in IDLE and RUN, and cleared on every state transition. The first step therefore occurs TS_DIV*STEP_DIV clocks after entering UP or DOWN, and subsequent steps follow every TS_DIV*STEP_DIV clocks.
- The duty register updates on the edge where the step pulse is high.
- Floor/ceiling target: ramp-up target T = i_target. Ramp-down floor F = go ? i_target : 0.
- IDLE: when go && i_target != 0, go to UP. Otherwise stay in IDLE with duty 0.
- UP:
  - Priority 1: if !go, go to DOWN.
  - Priority 2: if i_target < duty, go to DOWN.
  - Priority 3: if duty == T, go to RUN.
  - On a step pulse: duty = min(duty + STEP_SIZE, T). The sum is computed in DUTY_W+1 bits, so there is no wrap.
- RUN:
  - if !go or i_target < duty, go to DOWN.
  - if i_target > duty, go to UP.
  - duty is held.
- DOWN:
  - On a step pulse: duty = max(duty - STEP_SIZE, F). Underflow is guarded, so there is no wrap.
  - When duty == F: go to IDLE if F == 0, else go to RUN.
  - If go && i_target > duty, go to UP.
- Transition checks use the registered duty. When a step saturates the duty exactly to T or F, the transition happens on the following cycle.
- Fault: i_fault==1 has top priority in every state. On the next edge: duty=0, state IDLE, o_fault=1, prescalers cleared. o_fault stays set until a cycle with i_enable==0 and i_fault==0, then clears on that edge. Restart requires i_enable to be reasserted afterwards.
- Simultaneous events: reset > fault > stop/disable > target change > step.
- i_target == 0 with go behaves as a soft stop.
- o_done is asserted only in RUN. It drops on the same edge the state leaves RUN.

Test Plan (TS_DIV=4, STEP_DIV=2, STEP_SIZE=3, DUTY_W=8; one step per 8 clocks):
1. Release reset with i_enable=1, i_target=10 → duty steps 3, 6, 9, 10 at clocks 8/16/24/32 after entering UP. RUN and o_done=1 follow one cycle after the duty reaches 10. o_enable=0 until the first step.
2. From RUN at 10, raise i_stop → DOWN; duty steps 7, 4, 1, 0 every 8 clocks, then IDLE; o_enable=0 once duty is 0.
3. From RUN at 10, change i_target to 4 → DOWN; duty 7, 4, then RUN with o_done=1. Then set i_target=200 → UP; duty ramps to 200 and reaches RUN.
4. Mid-ramp at duty 6, pulse i_fault for 1 clock → next edge duty=0, IDLE, o_fault=1. o_fault stays set while i_enable=1. Drop i_enable for 1 clock → o_fault clears; reassert → ramp restarts from 0.
5. Mid-ramp at duty 9, assert reset (low) for 1 clock → all outputs 0 and state IDLE. Release reset → the first step lands 8 clocks after UP entry (prescaler cleared).
6. i_enable=1 with i_target=0 → stays IDLE, duty 0. Then i_target=255 with STEP_SIZE=100 → duty 100, 200, 255, with no overflow or wrap.
